// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// Holds the state encoding, control-bundle bit positions and default widths.
package id_ex_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int CTRL_ALUSRC   = 0;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_REGWRITE = 3;

   localparam int XLEN_DEF       = 32;
   localparam int REG_ADDR_W_DEF = 5;
   localparam int CTRL_W_DEF     = 4;
   localparam int COUNT_W_DEF    = 16;

endpackage

// File: rtl/id_ex_skid.sv
// Two-entry skid buffer on a flat payload with synchronous flush.
// One cycle latency; ready is decoded from state flops only, absorbing two entries under stall.
module id_ex_skid
   import id_ex_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_payload,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_payload
);

   state_t       state, state_nxt;
   logic [W-1:0] main_q, skid_q;
   logic         in_fire, out_fire;
   logic         load_main_in, load_main_skid, load_skid;

   assign in_ready    = (state != FULL);
   assign out_valid   = (state != EMPTY);
   assign out_payload = main_q;
   assign in_fire     = in_valid & in_ready;
   assign out_fire    = out_valid & out_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= EMPTY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state)
         EMPTY: if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_nxt = FULL;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
         end
         default: state_nxt = EMPTY;
      endcase
      // Squash only clears occupancy; payload flops keep whatever they held.
      if (flush) begin
         state_nxt      = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)        main_q <= in_payload;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_payload;
      end
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX stage: decoded operands, immediate, PC, rd and control carried decode -> execute.
// One cycle latency, full throughput; stalls absorb two entries before in_ready drops.
module id_ex_pipe
   import id_ex_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CTRL_W     = CTRL_W_DEF,
   parameter int COUNT_W    = COUNT_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_data_1,
   input  logic [XLEN-1:0]       in_data_2,
   input  logic [XLEN-1:0]       in_imm,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [CTRL_W-1:0]     in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_data_1,
   output logic [XLEN-1:0]       out_data_2,
   output logic [XLEN-1:0]       out_imm,
   output logic [XLEN-1:0]       out_pc,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [CTRL_W-1:0]     out_ctrl,
   output logic [COUNT_W-1:0]    bubble_count
);

   localparam int PW = 4*XLEN + REG_ADDR_W + CTRL_W;

   logic [PW-1:0] in_payload, out_payload;

   assign in_payload = {in_data_1, in_data_2, in_imm, in_pc, in_rd, in_ctrl};
   assign {out_data_1, out_data_2, out_imm, out_pc, out_rd, out_ctrl} = out_payload;

   id_ex_skid #(.W(PW)) u_skid (
      .clock       (clock),
      .reset_n     (reset_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (in_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         bubble_count <= '0;
      else if (!out_valid && (bubble_count != {COUNT_W{1'b1}}))
         bubble_count <= bubble_count + COUNT_W'(1);
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_id_ex_pipe;
   import id_ex_pkg::*;

   localparam int XLEN = 32, RW = 5, CW = 4, COUNT_W = 2;
   localparam int BMAX = (1 << COUNT_W) - 1;

   typedef struct packed {
      logic [XLEN-1:0] d1, d2, imm, pc;
      logic [RW-1:0]   rd;
      logic [CW-1:0]   ctrl;
   } ent_t;

   logic clock = 1'b0, reset_n, flush, in_valid, out_ready, in_ready, out_valid;
   ent_t cur;
   logic [XLEN-1:0] out_data_1, out_data_2, out_imm, out_pc;
   logic [RW-1:0]   out_rd;
   logic [CW-1:0]   out_ctrl;
   logic [COUNT_W-1:0] bubble_count;

   ent_t mq[$];
   int   mbub, n_cmp = 0, n_bad = 0;

   always #5 clock = ~clock;

   id_ex_pipe #(.XLEN(XLEN), .REG_ADDR_W(RW), .CTRL_W(CW), .COUNT_W(COUNT_W)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data_1(cur.d1), .in_data_2(cur.d2), .in_imm(cur.imm), .in_pc(cur.pc),
      .in_rd(cur.rd), .in_ctrl(cur.ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data_1(out_data_1), .out_data_2(out_data_2), .out_imm(out_imm), .out_pc(out_pc),
      .out_rd(out_rd), .out_ctrl(out_ctrl), .bubble_count(bubble_count)
   );

   function automatic ent_t dut_out();
      return {out_data_1, out_data_2, out_imm, out_pc, out_rd, out_ctrl};
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.d1 = $urandom; e.d2 = $urandom; e.imm = $urandom; e.pc = $urandom;
      e.rd = RW'($urandom);
      e.ctrl = '0;
      e.ctrl[CTRL_REGWRITE] = 1'($urandom);
      e.ctrl[CTRL_ALUSRC]   = 1'($urandom);
      e.ctrl[CTRL_MEMREAD]  = 1'($urandom);
      e.ctrl[CTRL_MEMWRITE] = 1'($urandom);
      return e;
   endfunction

   // Reference: FIFO of depth two; pops on consume, flush empties after the consume.
   task automatic step();
      bit inf, outf;
      inf  = in_valid && (mq.size() < 2);
      outf = (mq.size() > 0) && out_ready;
      if (mq.size() == 0 && mbub < BMAX) mbub++;
      @(posedge clock);
      if (outf) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (inf) mq.push_back(cur);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cur = '0;
      #3;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
      n_cmp++; if (dut_out() !== ent_t'(0)) begin n_bad++; $display("FAIL reset_payload: got %h need 0", dut_out()); end
      n_cmp++; if (bubble_count !== '0) begin n_bad++; $display("FAIL reset_bubble: got %0d need 0", bubble_count); end
      repeat (2) @(posedge clock);
      #1; reset_n = 1'b1; mq.delete(); mbub = 0;
   endtask

   task automatic test_bubble_sat();
      for (int i = 1; i <= 6; i++) begin
         step();
         n_cmp++;
         if (bubble_count !== COUNT_W'((i < BMAX) ? i : BMAX)) begin
            n_bad++; $display("FAIL bubble_sat[%0d]: got %0d need %0d", i, bubble_count, (i < BMAX) ? i : BMAX);
         end
      end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cur = rand_ent(); cur.d1 = XLEN'(i); in_valid = 1'b1;
         step();
         n_cmp++; if (out_valid !== 1'b1 || out_data_1 !== XLEN'(i)) begin
            n_bad++; $display("FAIL stream[%0d]: got v=%b d1=%0h need v=1 d1=%0h", i, out_valid, out_data_1, i);
         end
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d]: got %b need 1", i, in_ready); end
      end
      in_valid = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got %b need 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [XLEN-1:0] exp_d1 [6];
      logic            exp_rdy[6];
      logic [XLEN-1:0] seq[3];
      exp_d1  = '{32'hA, 32'hA, 32'hA, 32'hB, 32'hC, 32'h0};
      exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      seq     = '{32'hA, 32'hB, 32'hC};
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            cur = rand_ent(); cur.d1 = seq[(i < 2) ? i : 2]; in_valid = 1'b1;
         end else in_valid = 1'b0;
         if (i == 3) out_ready = 1'b1;
         if (i == 5) begin
            in_valid = 1'b0;
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b need 0", out_valid); end
         end else begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data_1 !== exp_d1[i]) begin
               n_bad++; $display("FAIL bp_data[%0d]: got v=%b d1=%0h need v=1 d1=%0h", i, out_valid, out_data_1, exp_d1[i]);
            end
            n_cmp++; if (in_ready !== exp_rdy[i]) begin
               n_bad++; $display("FAIL bp_ready[%0d]: got %b need %b", i, in_ready, exp_rdy[i]);
            end
         end
      end
   endtask

   task automatic test_flush_full();
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (2) begin cur = rand_ent(); step(); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_full_pre: got %b need 0", in_ready); end
      cur = rand_ent(); flush = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++; $display("FAIL flush_full: got v=%b r=%b need v=0 r=1", out_valid, in_ready);
      end
      flush = 1'b0; in_valid = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_full_after: got %b need 0", out_valid); end
   endtask

   task automatic test_flush_outfire();
      out_ready = 1'b0; cur = rand_ent(); cur.pc = 32'h100; in_valid = 1'b1;
      step();
      in_valid = 1'b1; cur = rand_ent(); flush = 1'b1; out_ready = 1'b1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
         n_bad++; $display("FAIL flush_fire_pc: got v=%b pc=%0h need v=1 pc=100", out_valid, out_pc);
      end
      step();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++; $display("FAIL flush_fire_after: got v=%b r=%b need v=0 r=1", out_valid, in_ready);
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (2) begin cur = rand_ent(); step(); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++; $display("FAIL arst_hs: got v=%b r=%b need v=0 r=1", out_valid, in_ready);
      end
      n_cmp++; if (dut_out() !== ent_t'(0) || bubble_count !== '0) begin
         n_bad++; $display("FAIL arst_state: got payload=%h bub=%0d need 0/0", dut_out(), bubble_count);
      end
      in_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1; mq.delete(); mbub = 0;
      cur = rand_ent(); in_valid = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b1 || dut_out() !== mq[0]) begin
         n_bad++; $display("FAIL arst_first_accept: got v=%b payload=%h", out_valid, dut_out());
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         cur       = rand_ent();
         step();
         n_cmp++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
            n_bad++; $display("FAIL rand_hs[%0d]: got v=%b r=%b need v=%b r=%b", i, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
         end
         if (mq.size() > 0) begin
            n_cmp++; if (dut_out() !== mq[0]) begin
               n_bad++; $display("FAIL rand_payload[%0d]: got %h need %h", i, dut_out(), mq[0]);
            end
         end
         n_cmp++; if (bubble_count !== COUNT_W'(mbub)) begin
            n_bad++; $display("FAIL rand_bubble[%0d]: got %0d need %0d", i, bubble_count, mbub);
         end
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bubble_sat();
      test_stream();
      test_backpressure();
      test_flush_full();
      test_flush_outfire();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline stage that carries decoded operands, immediate, PC, destination register and a packed control bundle from decode to execute. It replaces the free-running ID/EX register with a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, a synchronous flush for branch and exception squash, and a saturating bubble counter for performance monitoring. It sits between the decode stage (producer) and the ALU/execute stage (consumer).

## Interface
Parameters:
- XLEN, 32, data/immediate/PC width
- REG_ADDR_W, 5, register index width
- CTRL_W, 4, control bundle width; bit indices defined in package
- COUNT_W, 16, bubble counter width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held and incoming entries
- in_valid  in  1  decode presents an entry
- in_ready  out  1  stage accepts an entry this cycle
- in_data_1, in_data_2  in  XLEN  rs1/rs2 operand values
- in_imm  in  XLEN  sign-extended immediate
- in_pc  in  XLEN  instruction PC
- in_rd  in  REG_ADDR_W  destination register
- in_ctrl  in  CTRL_W  control bundle (alusrc, memread, memwrite, regwrite)
- out_valid  out  1  entry presented to execute
- out_ready  in  1  execute consumes entry this cycle
- out_data_1, out_data_2, out_imm, out_pc, out_rd, out_ctrl  out  widths as inputs  registered payload
- bubble_count  out  COUNT_W  cycles with out_valid=0

## Operation
- Transfer: in-fire = in_valid & in_ready; out-fire = out_valid & out_ready.
- Storage: main slot (drives outputs) and skid slot. State: EMPTY, ONE (main valid), FULL (main+skid valid).
- EMPTY: in-fire → main←in, ONE.
- ONE: in-fire & out-fire → main←in, stay ONE; in-fire only → skid←in, FULL; out-fire only → EMPTY; neither → hold.
- FULL: in_ready=0; out-fire → main←skid, ONE; else hold.
- in_ready = (state != FULL), decoded from state flops only; no combinational path from out_ready or in_valid.
- flush=1: next state EMPTY regardless of handshakes; incoming entry discarded; an out-fire in the flush cycle is a completed transfer (execute keeps it). Payload registers hold stale values; only valid state is cleared.
- Payload never changes while out_valid=1 and out_ready=0.
- bubble_count increments each cycle out_valid=0, saturates at 2^COUNT_W−1, cleared only by reset.
- Reset (asynchronous, reset_n=0): state EMPTY, out_valid=0, in_ready=1, all out_* payload=0, bubble_count=0, skid payload=0.

## Timing
- Latency: entry accepted at edge N is visible on outputs after edge N (one cycle) when EMPTY or when out-firing in ONE.
- Throughput: one entry per cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, at most two entries absorbed; in_ready falls the cycle after the second acceptance.
- Recovery: from FULL, out-fire at edge N → in_ready=1 after edge N.
- Reset deassertion: first acceptance possible at the first rising edge after reset_n rises.
- Bubble counter reflects out_valid of the previous cycle (registered increment).

## Structure
- Package id_ex_pkg: state enum (EMPTY, ONE, FULL); control index constants CTRL_ALUSRC=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_REGWRITE=3; default width constants.
- Sub-module id_ex_skid: generic 2-entry skid buffer on a flat payload of width 4*XLEN+REG_ADDR_W+CTRL_W with valid/ready and flush. Top level packs/unpacks payload fields and owns bubble_count.

## Test plan
- Reset then stream: in_valid=1 for 4 cycles, data_1=1..4, out_ready=1 → out_valid from cycle 1, out_data_1=1,2,3,4 on consecutive cycles, in_ready stays 1.
- Backpressure: out_ready=0, present data_1=0xA,0xB,0xC → 0xA, 0xB accepted, in_ready=0 while 0xC held; raise out_ready → outputs 0xA,0xB,0xC in order, no loss/duplication.
- Flush in FULL with in_valid=1, out_ready=0 → next cycle out_valid=0, in_ready=1, held and incoming entries dropped.
- Flush with simultaneous out-fire of pc=0x100 → 0x100 counted as transferred, next cycle out_valid=0.
- Bubble count: COUNT_W=2, idle 6 cycles after reset → bubble_count=3 (saturated); asynchronous reset_n pulse mid-stream → all outputs 0, in_ready=1 immediately.
